// File: rtl/serial_adder_ctrl_if.sv
// Host-side handshake and operand/result bundle for serial_adder_ctrl.
// SERIAL_ADDER_SUB_EN adds the i_sub request qualifier.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c;
`ifdef SERIAL_ADDER_SUB_EN
    logic             i_sub;
`endif
    logic             o_ready;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_c;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output i_sub,
`endif
        output i_start,
        output i_a,
        output i_b,
        output i_c,
        input  o_ready,
        input  o_done,
        input  o_sum,
        input  o_c
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  i_sub,
`endif
        input  i_start,
        input  i_a,
        input  i_b,
        input  i_c,
        output o_ready,
        output o_done,
        output o_sum,
        output o_c
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH-bit operands LSB first.
// Define SERIAL_ADDER_SUB_EN to enable subtraction via bus.i_sub.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                i_clk,
    input logic                i_rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH must be in 1..32");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ready_q;
    logic             done_q;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH:0]   sum_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full-adder cell on the current LSBs and the running carry.
    always_comb begin
        cell_s    = a_q[0] ^ b_q[0] ^ carry_q;
        cell_c    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        sum_shift = {cell_s, sum_q};
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; o_c then reads as "no borrow".
    always_comb begin
        b_load = bus.i_sub ? ~bus.i_b : bus.i_b;
        c_load = bus.i_sub ? 1'b1 : bus.i_c;
    end
`else
    always_comb begin
        b_load = bus.i_b;
        c_load = bus.i_c;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        a_q     <= bus.i_a;
                        b_q     <= b_load;
                        carry_q <= c_load;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q   <= sum_shift[WIDTH:1];
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= cell_c;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        cout_q  <= cell_c;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_done  = done_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_c     = cout_q;

    done_one_cycle: assert property (@(posedge i_clk) disable iff (i_rst) done_q |=> !done_q);
    ready_in_idle: assert property (@(posedge i_clk) disable iff (i_rst)
                                    ready_q == (state_q == StIdle));
endmodule
